// File: rtl/fifo_core.sv
// Single-clock FIFO with registered handshake pulses and combinational fill-level flags.
// Define FIFO_SVA_EN to compile in the embedded assertions and covers.
module fifo_core #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic wr_do, rd_do;

  assign full        = (count_reg == CNT_FULL);
  assign almostfull  = (count_reg == CNT_AFULL);
  assign empty       = (count_reg == '0);
  assign almostempty = (count_reg == CNT_W'(1));

  // Full/empty gate each side independently, so a simultaneous request at a boundary degrades to one side.
  assign wr_do = wr_en && !full;
  assign rd_do = rd_en && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_do) wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    if (rd_do) rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    case ({wr_do, rd_do})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_out   <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      wr_ack     <= wr_do;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      if (rd_do) data_out <= mem[rd_ptr_reg];
    end
  end

`ifdef FIFO_SVA_EN
  logic [3:0] flag_vec;
  assign flag_vec = {full, almostfull, almostempty, empty};

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_reg <= CNT_FULL);
  a_full:      assert property (@(posedge clk) disable iff (!rst_n) full == (count_reg == CNT_FULL));
  a_empty:     assert property (@(posedge clk) disable iff (!rst_n) empty == (count_reg == '0));
  a_overflow:  assert property (@(posedge clk) disable iff (!rst_n) wr_en && full |=> overflow && !wr_ack);
  a_underflow: assert property (@(posedge clk) disable iff (!rst_n) rd_en && empty |=> underflow);
  a_wr_ack:    assert property (@(posedge clk) disable iff (!rst_n) wr_en && !full |=> wr_ack);
  a_reset:     assert property (@(posedge clk) !rst_n |-> empty);

  for (genvar gi = 0; gi < 4; gi++) begin : g_flag_cov
    c_rise: cover property (@(posedge clk) disable iff (!rst_n) $rose(flag_vec[gi]));
    c_fall: cover property (@(posedge clk) disable iff (!rst_n) $fell(flag_vec[gi]));
  end

  c_wr_wrap: cover property (@(posedge clk) disable iff (!rst_n) wr_do && wr_ptr_reg == PTR_LAST);
  c_rd_wrap: cover property (@(posedge clk) disable iff (!rst_n) rd_do && rd_ptr_reg == PTR_LAST);
`endif

endmodule

// File: tb/tb_fifo_core.sv
// Scoreboard bench for fifo_core: a queue model predicts read data, handshake pulses and flags
// for each request cycle; outputs are checked 1 ns after the rising edge.
module tb_fifo_core;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] data_in;
  logic wr_en, rd_en;
  logic [W-1:0] data_out;
  logic wr_ack, overflow, underflow, full, almostfull, empty, almostempty;

  int vectors_applied = 0;
  int miscompares = 0;
  int txn = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_dout;
  logic exp_ack, exp_ovf, exp_udf;

  fifo_core #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    int n;
    n = model_q.size();
    check_val({ctx, ".data_out"},    32'(data_out),    32'(exp_dout));
    check_val({ctx, ".wr_ack"},      32'(wr_ack),      32'(exp_ack));
    check_val({ctx, ".overflow"},    32'(overflow),    32'(exp_ovf));
    check_val({ctx, ".underflow"},   32'(underflow),   32'(exp_udf));
    check_val({ctx, ".full"},        32'(full),        32'(n == D));
    check_val({ctx, ".almostfull"},  32'(almostfull),  32'(n == D - 1));
    check_val({ctx, ".empty"},       32'(empty),       32'(n == 0));
    check_val({ctx, ".almostempty"}, 32'(almostempty), 32'(n == 1));
  endtask

  task automatic model_reset();
    model_q.delete();
    sb_q.delete();
    exp_dout = '0;
    exp_ack  = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  // One request cycle: predict from the pre-edge fill level, clock once, compare.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string ctx);
    logic wa, ra;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    ra = r && (model_q.size() != 0);
    wa = w && (model_q.size() != D);
    if (ra) sb_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    exp_ack = wa;
    exp_ovf = w && !wa;
    exp_udf = r && !ra;
    @(posedge clk);
    #1;
    if (ra && sb_q.size() != 0) exp_dout = sb_q.pop_front();
    txn++;
    $display("txn %0d %s: wr=%0b rd=%0b din=%h -> dout=%h ack=%0b ovf=%0b udf=%0b flags(f/af/ae/e)=%0b%0b%0b%0b",
             txn, ctx, w, r, d, data_out, wr_ack, overflow, underflow, full, almostfull, almostempty, empty);
    check_outputs(ctx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 16'h5A5A;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // First cycle out of reset with both requests: write only, read underflows.
    step(1'b1, 1'b1, 16'h1111, "post_rst");
    step(1'b0, 1'b1, 16'h0000, "post_rst_rd");

    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), "fill");
    step(1'b1, 1'b0, 16'hDEAD, "ovf");
    repeat (9) step(1'b0, 1'b1, 16'h0000, "drain");

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0100 + i), "pre4");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'(16'h0200 + i), "simul4");

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0300 + i), "tofull");
    step(1'b1, 1'b1, 16'hBAD0, "simul_full");
    repeat (7) step(1'b0, 1'b1, 16'h0000, "toempty");
    step(1'b1, 1'b1, 16'h4444, "simul_empty");

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0500 + i), "to5");

    // Asynchronous reset mid-cycle while requests are pending.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 16'h6666;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h7777, "fresh_wr");
    step(1'b0, 1'b1, 16'h0000, "fresh_rd");
    check_val("fresh_data", 32'(data_out), 32'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
